// File: rtl/sequenciador_brinquedo.sv
// Toy automation controller: steps through a 6-position program with a dwell per step,
// pauses on a debounced proximity obstacle and resumes after a clear-time delay.
module sequenciador_brinquedo #(
  parameter int unsigned DWELL        = 8,
  parameter int unsigned DEB          = 4,
  parameter int unsigned RESUME_DELAY = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on_off,
  input  logic       sensor_prox,
  output logic [2:0] passo,
  output logic [1:0] estado,
  output logic       motor_en,
  output logic       led_alerta,
  output logic       buzzer,
  output logic       ciclo_completo
);

  typedef enum logic [1:0] {
    DESLIGADO = 2'b00,
    RODANDO   = 2'b01,
    PAUSA     = 2'b10,
    RETOMADA  = 2'b11
  } state_t;

  localparam int unsigned DW_W = $clog2(DWELL);
  localparam int unsigned DB_W = $clog2(DEB + 1);
  localparam int unsigned RD_W = $clog2(RESUME_DELAY + 1);

  logic            r_on_s1, r_on_s2;
  logic            r_se_s1, r_se_s2;
  logic            r_obst;
  logic [DB_W-1:0] r_deb_cnt;

  state_t          r_state, w_state_nx;
  logic [2:0]      r_passo, w_passo_nx;
  logic [DW_W-1:0] r_dwell, w_dwell_nx;
  logic [RD_W-1:0] r_rcnt, w_rcnt_nx;
  logic            r_ciclo, w_ciclo_nx;

  // Synchronizers and the stability filter on the synchronized sensor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_on_s1   <= 1'b0;
      r_on_s2   <= 1'b0;
      r_se_s1   <= 1'b0;
      r_se_s2   <= 1'b0;
      r_obst    <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_on_s1 <= on_off;
      r_on_s2 <= r_on_s1;
      r_se_s1 <= sensor_prox;
      r_se_s2 <= r_se_s1;
      if (r_se_s2 != r_obst) begin
        if (r_deb_cnt == DB_W'(DEB - 1)) begin
          r_obst    <= r_se_s2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + DB_W'(1);
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DESLIGADO;
      r_passo <= '0;
      r_dwell <= '0;
      r_rcnt  <= '0;
      r_ciclo <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_passo <= w_passo_nx;
      r_dwell <= w_dwell_nx;
      r_rcnt  <= w_rcnt_nx;
      r_ciclo <= w_ciclo_nx;
    end
  end

  // Power-off overrides every state; a pending obstacle beats a step advance.
  always_comb begin
    w_state_nx = r_state;
    w_passo_nx = r_passo;
    w_dwell_nx = r_dwell;
    w_rcnt_nx  = r_rcnt;
    w_ciclo_nx = 1'b0;
    if (!r_on_s2) begin
      w_state_nx = DESLIGADO;
      w_passo_nx = '0;
      w_dwell_nx = '0;
      w_rcnt_nx  = '0;
    end else begin
      unique case (r_state)
        DESLIGADO: begin
          w_state_nx = RODANDO;
          w_passo_nx = '0;
          w_dwell_nx = '0;
        end
        RODANDO: begin
          if (r_obst) begin
            w_state_nx = PAUSA;
          end else if (r_dwell == DW_W'(DWELL - 1)) begin
            w_dwell_nx = '0;
            if (r_passo == 3'd5) begin
              w_passo_nx = '0;
              w_ciclo_nx = 1'b1;
            end else begin
              w_passo_nx = r_passo + 3'd1;
            end
          end else begin
            w_dwell_nx = r_dwell + DW_W'(1);
          end
        end
        PAUSA: begin
          if (!r_obst) begin
            w_state_nx = RETOMADA;
            w_rcnt_nx  = '0;
          end
        end
        RETOMADA: begin
          if (r_obst) begin
            w_state_nx = PAUSA;
            w_rcnt_nx  = '0;
          end else if (r_rcnt == RD_W'(RESUME_DELAY - 1)) begin
            w_state_nx = RODANDO;
          end else begin
            w_rcnt_nx = r_rcnt + RD_W'(1);
          end
        end
      endcase
    end
  end

  assign passo          = r_passo;
  assign estado         = r_state;
  assign motor_en       = (r_state == RODANDO);
  assign led_alerta     = (r_state == PAUSA) || (r_state == RETOMADA);
  assign buzzer         = (r_state == PAUSA);
  assign ciclo_completo = r_ciclo;

endmodule

// File: tb/tb_sequenciador_brinquedo.sv
// Bench for sequenciador_brinquedo: abstract per-cycle model plus directed literal checks.
module tb_sequenciador_brinquedo;

  localparam int DWELL = 8;
  localparam int DEB   = 4;
  localparam int RD    = 6;

  logic       clk, reset, on_off, sensor_prox;
  logic [2:0] passo;
  logic [1:0] estado;
  logic       motor_en, led_alerta, buzzer, ciclo_completo;

  sequenciador_brinquedo #(.DWELL(DWELL), .DEB(DEB), .RESUME_DELAY(RD)) dut (
    .clk(clk), .reset(reset), .on_off(on_off), .sensor_prox(sensor_prox),
    .passo(passo), .estado(estado), .motor_en(motor_en), .led_alerta(led_alerta),
    .buzzer(buzzer), .ciclo_completo(ciclo_completo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int pulses   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: mode 0 off, 1 running, 2 paused, 3 resuming; progress is a tick count
  // through the 6*DWELL program, step = ticks / DWELL.
  int m_mode, m_t, m_rc, m_run;
  bit m_obst, m_pulse;
  bit on_h[2];
  bit se_h[2];

  always @(posedge clk or posedge reset) begin
    bit on_now, se_now, ob;
    if (reset) begin
      m_mode = 0; m_t = 0; m_rc = 0; m_run = 0; m_obst = 0; m_pulse = 0;
      on_h[0] = 0; on_h[1] = 0; se_h[0] = 0; se_h[1] = 0;
    end else begin
      on_now = on_h[1];
      se_now = se_h[1];
      ob = m_obst;
      m_pulse = 0;
      if (!on_now) begin
        m_mode = 0; m_t = 0; m_rc = 0;
      end else begin
        case (m_mode)
          0: m_mode = 1;
          1: if (ob) m_mode = 2;
             else begin
               m_t++;
               if (m_t == 6 * DWELL) begin m_t = 0; m_pulse = 1; end
             end
          2: if (!ob) begin m_mode = 3; m_rc = 0; end
          default: if (ob) begin m_mode = 2; m_rc = 0; end
                   else if (m_rc == RD - 1) m_mode = 1;
                   else m_rc++;
        endcase
      end
      if (se_now != m_obst) begin
        m_run++;
        if (m_run == DEB) begin m_obst = se_now; m_run = 0; end
      end else m_run = 0;
      on_h[1] = on_h[0]; on_h[0] = on_off;
      se_h[1] = se_h[0]; se_h[0] = sensor_prox;
    end
  end

  always @(negedge clk) begin
    int exp_v, got_v;
    if (!reset) begin
      exp_v = {m_t / DWELL, m_mode[1:0], m_mode == 1, m_mode >= 2, m_mode == 2, m_pulse};
      got_v = {passo, estado, motor_en, led_alerta, buzzer, ciclo_completo};
      chk("model", got_v, exp_v);
      if (ciclo_completo) pulses++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_run_t(input int tgt);
    int k;
    k = 0;
    while (!(m_mode == 1 && m_t == tgt) && k < 200) begin
      cyc(1);
      k++;
    end
    chk("reach_tick", (m_mode == 1 && m_t == tgt), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    reset = 1; on_off = 0; sensor_prox = 0;
    cyc(3);
    chk("reset_estado", estado, 0);
    chk("reset_outs", {passo, motor_en, led_alerta, buzzer, ciclo_completo}, 0);
    reset = 0;
    cyc(1);

    // Power on: RODANDO on the 3rd edge, step timing, cycle wrap pulse.
    on_off = 1;
    cyc(2);  chk("on_edge2", estado, 0);
    cyc(1);  chk("on_edge3", estado, 1);
    cyc(8);  chk("passo_after8", passo, 1);
    cyc(32); chk("passo_after40", passo, 5);
    cyc(7);  chk("passo_after47", passo, 5);
             chk("no_pulse47", ciclo_completo, 0);
    cyc(1);  chk("wrap_passo", passo, 0);
             chk("wrap_pulse", ciclo_completo, 1);
    cyc(1);  chk("pulse_one_cycle", ciclo_completo, 0);
    p0 = pulses;
    cyc(48); chk("pulses_per_48", pulses - p0, 1);

    // Obstacle at tick 13: six more running edges, pause held at passo 2 dwell 3.
    cyc(12);
    sensor_prox = 1;
    cyc(6);  chk("pre_pause_estado", estado, 1);
    cyc(1);  chk("pause_estado", estado, 2);
             chk("pause_outs", {passo, motor_en, led_alerta, buzzer}, {3'd2, 1'b0, 1'b1, 1'b1});
    cyc(13);
    sensor_prox = 0;
    cyc(6);  chk("still_pause", estado, 2);
    cyc(1);  chk("retomada_estado", estado, 3);
             chk("retomada_outs", {buzzer, led_alerta, motor_en}, 3'b010);
    cyc(5);  chk("retomada_hold", estado, 3);
    cyc(1);  chk("resume_run", estado, 1);
             chk("resume_passo", passo, 2);
    cyc(4);  chk("resume_passo4", passo, 2);
    cyc(1);  chk("resume_advance", passo, 3);

    // Short glitches are filtered out.
    repeat (4) begin
      sensor_prox = 1; cyc(3);
      sensor_prox = 0; cyc(5);
      chk("glitch_estado", estado, 1);
    end
    chk("glitch_passo", passo, 1);

    // Re-obstruct during RETOMADA at resume count 4.
    sensor_prox = 1;
    cyc(7);  chk("p2_pause", estado, 2);
    cyc(3);
    sensor_prox = 0;
    cyc(5);
    sensor_prox = 1;
    cyc(6);  chk("p2_retomada_rc4", estado, 3);
    cyc(1);  chk("p2_back_pause", estado, 2);
    cyc(3);
    sensor_prox = 0;
    cyc(6);  chk("p2_pause_hold", estado, 2);
    cyc(1);  chk("p2_retomada", estado, 3);
    cyc(5);  chk("p2_full_delay", estado, 3);
    cyc(1);  chk("p2_run", estado, 1);

    // Power off while paused at passo 4.
    wait_run_t(28);
    sensor_prox = 1;
    cyc(7);  chk("off_pause", estado, 2);
             chk("off_pause_passo", passo, 4);
    on_off = 0;
    cyc(2);  chk("off_edge2", estado, 2);
    cyc(1);  chk("off_edge3", {passo, estado, motor_en, led_alerta, buzzer, ciclo_completo}, 0);
    sensor_prox = 0;
    cyc(8);
    on_off = 1;
    cyc(3);  chk("restart_estado", estado, 1);
             chk("restart_passo", passo, 0);

    // Asynchronous reset mid-run at passo 3, between edges.
    wait_run_t(26);
    chk("pre_reset_passo", passo, 3);
    #2 reset = 1;
    #1 chk("async_reset", {passo, estado, motor_en, led_alerta, buzzer, ciclo_completo}, 0);
    cyc(2);
    reset = 0;
    cyc(3);  chk("post_reset_estado", estado, 1);
             chk("post_reset_passo", passo, 0);
    cyc(8);  chk("post_reset_step", passo, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sequenciador_brinquedo.md
Name: sequenciador_brinquedo

Overview:
- Top-level controller for the toy automation.
- Steps the toy through a 6-position program (step 0..5), holding each step for a programmable dwell time.
- Gated by the on/off switch; halts safely when the proximity sensor detects an obstacle; resumes only after the obstacle has been clear for a programmable delay.
- Drives the motor enable, alert LED and buzzer, and exposes the current step to the display logic.

Parameters:
- DWELL, 8: clk cycles spent in each step while running (min 2).
- DEB, 4: consecutive stable synchronized cycles required before the filtered sensor changes (min 1).
- RESUME_DELAY, 6: clk cycles the obstacle must stay clear before motion restarts (min 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- on_off  input  1  toy power switch, asynchronous to clk, 1 = on.
- sensor_prox  input  1  proximity sensor, asynchronous, 1 = obstacle.
- passo  output  3  current program step, 0..5.
- estado  output  2  FSM state: 00 DESLIGADO, 01 RODANDO, 10 PAUSA, 11 RETOMADA.
- motor_en  output  1  1 only in RODANDO.
- led_alerta  output  1  1 in PAUSA or RETOMADA.
- buzzer  output  1  1 only in PAUSA.
- ciclo_completo  output  1  one-cycle pulse on the step 5 -> 0 wrap.

Behaviour:
- Reset, asynchronous and active-high, clears all of the following:
  - state goes to DESLIGADO; passo=0;
  - all counters, synchronizer flops and the filtered sensor go to 0;
  - all outputs go to 0.
- Input synchronization:
  - on_off and sensor_prox each pass through a 2-flop synchronizer before any use.
  - on_off_s is not debounced.
- Sensor filter:
  - obst is a registered copy of the synchronized sensor.
  - obst changes only after the synchronized sensor has differed from obst for DEB consecutive cycles.
  - The stability counter clears on any cycle where the two agree.
  - Glitches shorter than DEB cycles are ignored.
- Dwell counter: 0..DWELL-1; counts only in RODANDO.
  - At DWELL-1 it wraps to 0 and passo advances: 0->1->2->3->4->5->0.
  - On 5->0, ciclo_completo=1 for exactly that cycle.
  - passo never takes values 6 or 7.
- FSM, evaluated every clk edge; on_off_s=0 has the highest priority in every state:
  - DESLIGADO: passo=0, dwell=0. If on_off_s=1 -> RODANDO.
  - RODANDO:
    - on_off_s=0 -> DESLIGADO (passo and dwell cleared on the same edge).
    - Else if obst=1 -> PAUSA; passo and dwell are held and not advanced.
    - Else count/advance.
  - PAUSA: passo and dwell held. If obst=0 -> RETOMADA and the resume counter is cleared.
  - RETOMADA: the resume counter increments each cycle.
    - If obst=1 -> PAUSA and the resume counter is cleared.
    - When the counter reaches RESUME_DELAY-1 with obst=0 -> RODANDO. Dwell continues from its held value; it is not restarted.
- Simultaneous events:
  - Dwell at DWELL-1 and obst=1 on the same edge: the pause wins and passo does not advance. The advance occurs on the first RODANDO cycle after resume.
  - on_off_s falling while in PAUSA or RETOMADA: go straight to DESLIGADO with passo=0.
- Outputs are registered or decoded directly from registered state, with no combinational path from inputs.
- Latency:
  - The on_off edge is reflected in estado on the 3rd rising clk edge after the change.
  - A sensor assertion reaches PAUSA on edge 2+DEB+1.
- Reset asserted mid-operation: immediate return to DESLIGADO, passo=0, no ciclo_completo pulse.

Test Plan:
- Reset, then on_off=1 held, sensor=0:
  - estado=01 after the 3rd edge;
  - passo=1 after 8 RODANDO cycles;
  - passo=5 after 40;
  - passo=0 with ciclo_completo=1 for one cycle after 48; pulse count 1 per 48 cycles.
- At passo=2, dwell=3, assert sensor_prox for 20 cycles:
  - PAUSA 7 edges after assertion, with motor_en=0, buzzer=1, led_alerta=1, passo=2 held;
  - after release, RETOMADA (buzzer=0, led_alerta=1);
  - then RODANDO after 6 clear cycles, and passo=3 exactly 5 RODANDO cycles later.
- Sensor glitches of 3 cycles, repeated while running: estado stays 01 and passo timing is unchanged.
- During RETOMADA (resume count 4), re-assert the sensor for 10 cycles: returns to PAUSA; after release, the full 6-cycle RETOMADA is required again.
- on_off=0 during PAUSA at passo=4: estado=00 and passo=0 on the 3rd edge; all outputs 0. on_off=1 restarts from passo=0.
- Assert reset asynchronously mid-RODANDO at passo=3, between clock edges: outputs go to 0 and estado=00 immediately, before the next edge. After release with on_off=1, the sequence restarts at passo=0.
